// File: rtl/cs_ctrl.sv
// rtl/cs_ctrl.sv - clip-and-split controller between transform stage, cs_stack and rasteriser
// Triangle bus: vertex i at [48*i +: 48], each vertex packed {z, y, x} as signed 16-bit fields.
module cs_ctrl #(
  parameter logic signed [15:0] ZNEAR    = 16'sd1,
  parameter logic signed [15:0] ZFAR     = 16'sd4095,
  parameter int                 MAX_EDGE = 64
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [143:0] tri_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [143:0] tri_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [143:0] stk_tri_out,
  output logic         stk_push,
  output logic         stk_pop,
  input  logic [143:0] stk_tri_in,
  input  logic         stk_empty,
  input  logic         stk_full
);

  typedef enum logic [1:0] {IDLE, TEST, EMIT, LOAD} state_t;

  localparam logic [17:0] MAX_LEN = 18'(MAX_EDGE);

  state_t             state, state_nxt;
  logic [143:0]       cur;
  logic signed [15:0] vx [3];
  logic signed [15:0] vy [3];
  logic signed [15:0] vz [3];
  logic [17:0]        len [3];
  logic [1:0]         sel;
  logic [1:0]         ea, eb;
  logic [47:0]        mid_v;
  logic [143:0]       child_a, child_b;
  logic               cull, split;

  function automatic logic [17:0] edge_len(input logic signed [15:0] xa, ya, xb, yb);
    logic signed [16:0] dx, dy;
    logic [16:0]        ax, ay;
    dx = 17'(xa) - 17'(xb);
    dy = 17'(ya) - 17'(yb);
    ax = dx[16] ? 17'(-dx) : 17'(dx);
    ay = dy[16] ? 17'(-dy) : 17'(dy);
    return 18'(ax) + 18'(ay);
  endfunction

  // floor((a+b)/2): 17-bit sum then arithmetic shift
  function automatic logic [15:0] mid(input logic signed [15:0] a, b);
    logic signed [16:0] s;
    s = (17'(a) + 17'(b)) >>> 1;
    return 16'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      vx[i] = cur[48*i +: 16];
      vy[i] = cur[48*i+16 +: 16];
      vz[i] = cur[48*i+32 +: 16];
    end
  end

  assign len[0] = edge_len(vx[0], vy[0], vx[1], vy[1]);
  assign len[1] = edge_len(vx[1], vy[1], vx[2], vy[2]);
  assign len[2] = edge_len(vx[2], vy[2], vx[0], vy[0]);

  always_comb begin
    sel = 2'd2;
    ea  = 2'd2;
    eb  = 2'd0;
    if (len[0] >= len[1] && len[0] >= len[2]) begin
      sel = 2'd0; ea = 2'd0; eb = 2'd1;
    end else if (len[1] >= len[2]) begin
      sel = 2'd1; ea = 2'd1; eb = 2'd2;
    end
  end

  assign mid_v = {mid(vz[ea], vz[eb]), mid(vy[ea], vy[eb]), mid(vx[ea], vx[eb])};

  always_comb begin
    child_a = cur;
    child_b = cur;
    case (sel)
      2'd0: begin
        child_a = {cur[143:96], mid_v, cur[47:0]};
        child_b = {cur[143:48], mid_v};
      end
      2'd1: begin
        child_a = {mid_v, cur[95:0]};
        child_b = {cur[143:96], mid_v, cur[47:0]};
      end
      default: begin
        child_a = {mid_v, cur[95:0]};
        child_b = {cur[143:48], mid_v};
      end
    endcase
  end

  assign cull  = (vz[0] < ZNEAR && vz[1] < ZNEAR && vz[2] < ZNEAR) ||
                 (vz[0] > ZFAR  && vz[1] > ZFAR  && vz[2] > ZFAR);
  // a full stack forces emission of the oversized triangle as-is
  assign split = (len[sel] > MAX_LEN) && !stk_full;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = TEST;
      TEST: begin
        if (cull)       state_nxt = stk_empty ? IDLE : LOAD;
        else if (!split) state_nxt = EMIT;
      end
      EMIT: if (out_ready) state_nxt = stk_empty ? IDLE : LOAD;
      LOAD: state_nxt = TEST;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == EMIT);
    stk_push  = (state == TEST) && !cull && split;
    stk_pop   = ((state == TEST) && cull && !stk_empty) ||
                ((state == EMIT) && out_ready && !stk_empty);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cur <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) cur <= tri_in;
        TEST: if (!cull && split) cur <= child_a;
        LOAD: cur <= stk_tri_in;
        default: cur <= cur;
      endcase
    end
  end

  assign tri_out     = cur;
  assign stk_tri_out = child_b;

endmodule

// File: tb/tb_cs_ctrl.sv
// tb/tb_cs_ctrl.sv - bench for cs_ctrl with a behavioural triangle stack and depth-first split model
module tb_cs_ctrl;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [143:0] tri_in      [2];
  logic         in_valid    [2];
  logic         in_ready    [2];
  logic [143:0] tri_out     [2];
  logic         out_valid   [2];
  logic         out_ready   [2];
  logic [143:0] stk_tri_out [2];
  logic         stk_push    [2];
  logic         stk_pop     [2];
  logic [143:0] stk_tri_in  [2];
  logic         stk_empty   [2];
  logic         stk_full    [2];

  int n_cmp = 0;
  int n_err = 0;
  int push_cnt [2] = '{0, 0};
  int pop_cnt  [2] = '{0, 0};

  logic [143:0] exp_mem [2][4096];
  int exp_wr [2] = '{0, 0};
  int exp_rd [2] = '{0, 0};

  logic [143:0] mres [4096];
  int mcnt;

  always #5 clk = ~clk;

  cs_ctrl #(.ZNEAR(16'sd1), .ZFAR(16'sd4095), .MAX_EDGE(64)) dut_a (
    .clk(clk), .n_rst(n_rst), .tri_in(tri_in[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .tri_out(tri_out[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .stk_tri_out(stk_tri_out[0]), .stk_push(stk_push[0]), .stk_pop(stk_pop[0]),
    .stk_tri_in(stk_tri_in[0]), .stk_empty(stk_empty[0]), .stk_full(stk_full[0]));

  cs_ctrl #(.ZNEAR(16'sd1), .ZFAR(16'sd4095), .MAX_EDGE(2)) dut_b (
    .clk(clk), .n_rst(n_rst), .tri_in(tri_in[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .tri_out(tri_out[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .stk_tri_out(stk_tri_out[1]), .stk_push(stk_push[1]), .stk_pop(stk_pop[1]),
    .stk_tri_in(stk_tri_in[1]), .stk_empty(stk_empty[1]), .stk_full(stk_full[1]));

  function automatic int depth_of(int i);
    return (i == 0) ? 8 : 3;
  endfunction

  function automatic int me_of(int i);
    return (i == 0) ? 64 : 2;
  endfunction

  // Stack: registered pop data, valid the cycle after the pop
  logic [143:0] stk_mem [2][8];
  int stk_cnt [2];

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 2; i++) begin
        stk_cnt[i]    <= 0;
        stk_tri_in[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (stk_push[i] && stk_cnt[i] < depth_of(i)) begin
          stk_mem[i][stk_cnt[i]] <= stk_tri_out[i];
          stk_cnt[i]             <= stk_cnt[i] + 1;
        end else if (stk_pop[i] && stk_cnt[i] > 0) begin
          stk_tri_in[i] <= stk_mem[i][stk_cnt[i]-1];
          stk_cnt[i]    <= stk_cnt[i] - 1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stk_empty[i] = (stk_cnt[i] == 0);
      stk_full[i]  = (stk_cnt[i] == depth_of(i));
    end
  end

  task automatic check(input string nm, input logic [143:0] act, input logic [143:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  function automatic logic [143:0] tri3(int x0, int y0, int x1, int y1, int x2, int y2, int z);
    return {16'(z), 16'(y2), 16'(x2), 16'(z), 16'(y1), 16'(x1), 16'(z), 16'(y0), 16'(x0)};
  endfunction

  function automatic int comp(logic [143:0] t, int v, int c);
    logic [15:0] w;
    w = t[v*48 + c*16 +: 16];
    return int'($signed(w));
  endfunction

  function automatic int iabs(int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic int elen(logic [143:0] t, int a, int b);
    return iabs(comp(t, a, 0) - comp(t, b, 0)) + iabs(comp(t, a, 1) - comp(t, b, 1));
  endfunction

  function automatic int max_len(logic [143:0] t);
    int m;
    m = elen(t, 0, 1);
    if (elen(t, 1, 2) > m) m = elen(t, 1, 2);
    if (elen(t, 2, 0) > m) m = elen(t, 2, 0);
    return m;
  endfunction

  function automatic int fmid(int p, int q);
    int s;
    s = p + q;
    return (s >= 0) ? s / 2 : -((1 - s) / 2);
  endfunction

  // Depth-first bisection with a bounded LIFO; each child replaces one vertex by the midpoint
  task automatic run_model(input logic [143:0] t, input int me, input int depth);
    logic [143:0] stk [$];
    logic [143:0] cur, ca, cb;
    int l [3];
    int e, a, b, zl, zh;
    int rep_a [3] = '{1, 2, 2};
    int rep_b [3] = '{0, 1, 0};
    logic [47:0] mv;
    mcnt = 0;
    cur  = t;
    forever begin
      zl = 0; zh = 0;
      for (int v = 0; v < 3; v++) begin
        if (comp(cur, v, 2) < 1)    zl++;
        if (comp(cur, v, 2) > 4095) zh++;
      end
      if (zl == 3 || zh == 3) begin
        if (stk.size() == 0) break;
        cur = stk.pop_back();
        continue;
      end
      l[0] = elen(cur, 0, 1); l[1] = elen(cur, 1, 2); l[2] = elen(cur, 2, 0);
      e = 0;
      if (l[1] > l[e]) e = 1;
      if (l[2] > l[e]) e = 2;
      if (l[e] > me && stk.size() < depth) begin
        a  = e;
        b  = (e + 1) % 3;
        mv = {16'(fmid(comp(cur, a, 2), comp(cur, b, 2))),
              16'(fmid(comp(cur, a, 1), comp(cur, b, 1))),
              16'(fmid(comp(cur, a, 0), comp(cur, b, 0)))};
        ca = cur; ca[rep_a[e]*48 +: 48] = mv;
        cb = cur; cb[rep_b[e]*48 +: 48] = mv;
        stk.push_back(cb);
        cur = ca;
      end else begin
        if (mcnt < 4096) mres[mcnt] = cur;
        mcnt++;
        if (stk.size() == 0) break;
        cur = stk.pop_back();
      end
    end
  endtask

  task automatic load_exp(input int i);
    for (int k = 0; k < mcnt && k < 4096; k++) begin
      exp_mem[i][exp_wr[i] % 4096] = mres[k];
      exp_wr[i]++;
    end
  endtask

  task automatic send(input int i, input logic [143:0] t);
    int n = 0;
    while (!in_ready[i] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready", 144'(in_ready[i]), 144'(1));
    tri_in[i]   = t;
    in_valid[i] = 1'b1;
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n = 0;
    while (!(in_ready[i] && exp_rd[i] == exp_wr[i]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_in_budget", 144'(n < budget), 144'(1));
  endtask

  // Per-cycle protocol and data checks against the model's expected outputs
  initial begin
    logic pv [2];
    logic pr [2];
    logic ppop [2];
    logic [143:0] pt [2];
    for (int i = 0; i < 2; i++) begin
      pv[i] = 0; pr[i] = 0; ppop[i] = 0; pt[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!n_rst) begin
          pv[i] = 0; ppop[i] = 0;
          continue;
        end
        if (stk_push[i] || stk_pop[i]) begin
          check("push_pop_exclusive", 144'(stk_push[i] && stk_pop[i]), 144'(0));
          if (stk_push[i]) begin
            check("push_while_full", 144'(stk_full[i]), 144'(0));
            push_cnt[i]++;
          end
          if (stk_pop[i]) pop_cnt[i]++;
        end
        if (ppop[i])
          check("load_after_pop", 144'({stk_push[i], stk_pop[i], out_valid[i]}), 144'(0));
        if (pv[i] && !pr[i]) begin
          check("hold_valid", 144'(out_valid[i]), 144'(1));
          check("hold_data", tri_out[i], pt[i]);
        end
        if (out_valid[i] && out_ready[i]) begin
          if (exp_rd[i] == exp_wr[i]) begin
            check("out_extra", 144'(out_valid[i]), 144'(0));
          end else begin
            check("out_tri", tri_out[i], exp_mem[i][exp_rd[i] % 4096]);
            exp_rd[i]++;
          end
          if (max_len(tri_out[i]) > me_of(i))
            check("oversize_only_when_full", 144'(stk_full[i]), 144'(1));
        end
        pv[i] = out_valid[i]; pr[i] = out_ready[i]; pt[i] = tri_out[i]; ppop[i] = stk_pop[i];
      end
    end
  end

  initial begin
    logic [143:0] t1, t3, t5, tz;
    int p0, q0, r0, n;

    n_rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tri_in[i] = '0; in_valid[i] = 1'b0; out_ready[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_in_ready", 144'(in_ready[i]), 144'(1));
      check("rst_out_valid", 144'(out_valid[i]), 144'(0));
      check("rst_tri_out", tri_out[i], '0);
      check("rst_push_pop", 144'({stk_push[i], stk_pop[i]}), 144'(0));
    end
    @(posedge clk); #1;
    n_rst = 1'b1;

    // small triangle passes straight through
    t1 = tri3(0, 0, 4, 0, 0, 4, 10);
    run_model(t1, 64, 8);
    check("model_t1_count", 144'(mcnt), 144'(1));
    check("model_t1_tri", mres[0], t1);
    load_exp(0);
    p0 = push_cnt[0]; q0 = pop_cnt[0];
    send(0, t1);
    check("t1_valid_c1", 144'(out_valid[0]), 144'(0));
    @(posedge clk); #1;
    check("t1_valid_c2", 144'(out_valid[0]), 144'(1));
    check("t1_tri_out", tri_out[0], t1);
    @(posedge clk); #1;
    check("t1_in_ready_after", 144'(in_ready[0]), 144'(1));
    check("t1_no_stack", 144'({push_cnt[0] - p0, pop_cnt[0] - q0}), 144'(0));
    check("t1_drained", 144'(exp_wr[0] - exp_rd[0]), 144'(0));

    // near-culled then far-culled
    for (int k = 0; k < 2; k++) begin
      tz = tri3(0, 0, 4, 0, 0, 4, (k == 0) ? -5 : 5000);
      run_model(tz, 64, 8);
      check("model_cull_count", 144'(mcnt), 144'(0));
      p0 = push_cnt[0]; q0 = pop_cnt[0];
      send(0, tz);
      check("cull_busy", 144'({in_ready[0], out_valid[0]}), 144'(0));
      @(posedge clk); #1;
      check("cull_ready_back", 144'({in_ready[0], out_valid[0]}), 144'(2));
      check("cull_no_stack", 144'({push_cnt[0] - p0, pop_cnt[0] - q0}), 144'(0));
    end

    // two-level split, depth-first order
    t3 = tri3(0, 0, 100, 0, 0, 20, 10);
    run_model(t3, 64, 8);
    check("model_t3_count", 144'(mcnt), 144'(3));
    check("model_t3_0", mres[0], tri3(0, 0, 50, 0, 50, 10, 10));
    check("model_t3_1", mres[1], tri3(50, 0, 100, 0, 50, 10, 10));
    check("model_t3_2", mres[2], tri3(0, 0, 50, 10, 0, 20, 10));
    load_exp(0);
    p0 = push_cnt[0]; q0 = pop_cnt[0];
    send(0, t3);
    wait_done(0, 200);
    check("t3_pushes", 144'(push_cnt[0] - p0), 144'(2));
    check("t3_pops", 144'(pop_cnt[0] - q0), 144'(2));

    // backpressure on the output
    out_ready[0] = 1'b0;
    run_model(t1, 64, 8);
    load_exp(0);
    r0 = exp_rd[0];
    send(0, t1);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid_held", 144'(out_valid[0]), 144'(1));
      check("bp_tri_held", tri_out[0], t1);
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_single_transfer", 144'(exp_rd[0] - r0), 144'(1));
    check("bp_in_ready", 144'(in_ready[0]), 144'(1));

    // tiny MAX_EDGE against a three-deep stack
    t5 = tri3(0, 0, 1000, 0, 0, 1000, 10);
    run_model(t5, 2, 3);
    check("model_t5_nonempty", 144'(mcnt > 3), 144'(1));
    load_exp(1);
    p0 = push_cnt[1]; q0 = pop_cnt[1];
    send(1, t5);
    wait_done(1, 60000);
    check("t5_end_empty", 144'({stk_empty[1], in_ready[1]}), 144'(3));
    check("t5_push_eq_pop", 144'(push_cnt[1] - p0), 144'(pop_cnt[1] - q0));
    check("t5_pushed", 144'(push_cnt[1] - p0 > 0), 144'(1));

    // reset in the middle of a split sequence
    run_model(t3, 64, 8);
    load_exp(0);
    r0 = exp_rd[0];
    send(0, t3);
    n = 0;
    while (exp_rd[0] == r0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_first_out", 144'(n < 100), 144'(1));
    @(posedge clk); #1;
    n_rst = 1'b0;
    @(negedge clk);
    check("mid_rst_tri", tri_out[0], '0);
    check("mid_rst_flags", 144'({out_valid[0], stk_push[0], stk_pop[0]}), 144'(0));
    check("mid_rst_ready", 144'({in_ready[0], stk_empty[0]}), 144'(3));
    exp_wr[0] = exp_rd[0];
    @(posedge clk); #1;
    n_rst = 1'b1;
    run_model(t1, 64, 8);
    load_exp(0);
    send(0, t1);
    wait_done(0, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
